segment_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a multi-digit 7-segment display. It holds one 4-bit code per digit, walks a one-hot digit enable across the digits at a programmable refresh rate, and shares a single `SegmentLogic` decoder instance across all digits. A blanking guard between digits prevents ghosting. It sits between the host register interface and the display pins.

---
 rtl/segment_pkg.sv | 14 +
 rtl/segment_scan_ctrl_logic.sv | 26 ++
 rtl/segment_scan_ctrl.sv | 126 ++++++++++++
 tb/tb_segment_scan_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/segment_pkg.sv
// Shared constants and FSM state type for the 7-segment scan controller.
package segment_pkg;

    localparam logic [6:0] SEG_BLANK        = 7'h00;
    localparam logic [3:0] DIGIT_BLANK      = 4'hF;
    localparam logic [3:0] MAX_DISPLAY_CODE = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } scan_state_e;

endpackage

// File: rtl/segment_scan_ctrl_logic.sv
// BCD-to-7-segment decoder, gfedcba active-high; codes above 9 decode dark.
module SegmentLogic
    import segment_pkg::*;
(
    input  logic [3:0] din,
    output logic [6:0] dout
);

    always_comb begin
        dout = SEG_BLANK;
        case (din)
            4'd0: dout = 7'h3F;
            4'd1: dout = 7'h06;
            4'd2: dout = 7'h5B;
            4'd3: dout = 7'h4F;
            4'd4: dout = 7'h66;
            4'd5: dout = 7'h6D;
            4'd6: dout = 7'h7D;
            4'd7: dout = 7'h07;
            4'd8: dout = 7'h7F;
            4'd9: dout = 7'h6F;
            default: dout = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/segment_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: digit store, one-hot digit walk
// with a dark guard at the start of every slot, and one shared decoder.
module segment_scan_ctrl
    import segment_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          wr_en,
    input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
    input  logic [3:0]                    wr_data,
    output logic [6:0]                    seg_code,
    output logic [NUM_DIGITS-1:0]         digit_en,
    output logic                          frame_tick
);

    localparam int AW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(REFRESH_DIV);

    scan_state_e           state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic [3:0]            store_q [NUM_DIGITS];
    logic [6:0]            segCode_q, segCode_d;
    logic [NUM_DIGITS-1:0] digitEn_q, digitEn_d;
    logic                  frameTick_q, frameTick_d;
    logic [3:0]            curCode;
    logic [6:0]            decoded;

    assign curCode = store_q[idx_q];

    SegmentLogic u_segment_logic (
        .din  (curCode),
        .dout (decoded)
    );

    // Out-of-range addresses can only occur when NUM_DIGITS is not a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                store_q[i] <= DIGIT_BLANK;
            end
        end else if (wr_en && (int'(wr_addr) < NUM_DIGITS)) begin
            store_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            segCode_q   <= SEG_BLANK;
            digitEn_q   <= '0;
            frameTick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            segCode_q   <= segCode_d;
            digitEn_q   <= digitEn_d;
            frameTick_q <= frameTick_d;
        end
    end

    // Output next-values come from the current state, so the pins lag the FSM
    // by one cycle; dropping enable darkens them on the very next edge.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        segCode_d   = SEG_BLANK;
        digitEn_d   = '0;
        frameTick_d = 1'b0;

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
                BLANK: begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
                        state_d = SHOW;
                    end
                end
                SHOW: begin
                    digitEn_d = NUM_DIGITS'(1) << idx_q;
                    segCode_d = (curCode <= MAX_DISPLAY_CODE) ? decoded : SEG_BLANK;
                    if (cnt_q == CW'(REFRESH_DIV - 1)) begin
                        cnt_d   = '0;
                        state_d = BLANK;
                        if (idx_q == AW'(NUM_DIGITS - 1)) begin
                            idx_d       = '0;
                            frameTick_d = 1'b1;
                        end else begin
                            idx_d = idx_q + AW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    assign seg_code   = segCode_q;
    assign digit_en   = digitEn_q;
    assign frame_tick = frameTick_q;

endmodule

// File: tb/tb_segment_scan_ctrl.sv
// Directed bench for segment_scan_ctrl: a 4-digit and a 3-digit build share
// stimulus and are checked every cycle against a slot-arithmetic model.
`timescale 1ns/1ps
module tb_segment_scan_ctrl;

    localparam int R = 8;
    localparam int B = 2;

    logic       clk     = 1'b0;
    logic       rst     = 1'b0;
    logic       enable  = 1'b0;
    logic       wr_en   = 1'b0;
    logic [1:0] wr_addr = 2'd0;
    logic [3:0] wr_data = 4'd0;

    logic [6:0] seg4, seg3;
    logic [3:0] en4;
    logic [2:0] en3;
    logic       tick4, tick3;

    int errors    = 0;
    int checks    = 0;
    int edgeCount = 0;
    int base      = 0;
    int lastTick  = -1;

    always #5 clk = ~clk;

    always @(posedge clk) edgeCount <= edgeCount + 1;

    segment_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut4 (
        .clk(clk), .rst(rst), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .seg_code(seg4), .digit_en(en4), .frame_tick(tick4)
    );

    segment_scan_ctrl #(.NUM_DIGITS(3), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut3 (
        .clk(clk), .rst(rst), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .seg_code(seg3), .digit_en(en3), .frame_tick(tick3)
    );

    function automatic logic [6:0] segTable(logic [3:0] code);
        case (code)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Packed as {frame_tick, digit_en[7:0], seg_code[6:0]} for a scan that has
    // been running for 'age' cycles since it entered its first guard.
    function automatic logic [15:0] expectedOut(int age, int nd, logic [3:0] code);
        int         slot = (age / R) % nd;
        int         pos  = age % R;
        logic [7:0] en   = 8'd0;
        logic [6:0] seg  = 7'd0;
        logic       tick;
        if (pos >= B) begin
            en  = 8'd1 << slot;
            seg = (code <= 4'd9) ? segTable(code) : 7'h00;
        end
        tick = (pos == R - 1) && (slot == nd - 1);
        return {tick, en, seg};
    endfunction

    logic        scanning;
    int          age;
    logic [3:0]  store4 [4];
    logic [3:0]  store3 [3];
    logic [15:0] exp4, exp3;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            scanning <= 1'b0;
            age      <= 0;
            exp4     <= '0;
            exp3     <= '0;
            for (int i = 0; i < 4; i++) store4[i] <= 4'hF;
            for (int i = 0; i < 3; i++) store3[i] <= 4'hF;
        end else begin
            if (!enable) begin
                scanning <= 1'b0;
                age      <= 0;
                exp4     <= '0;
                exp3     <= '0;
            end else if (!scanning) begin
                scanning <= 1'b1;
                age      <= 0;
                exp4     <= '0;
                exp3     <= '0;
            end else begin
                age  <= age + 1;
                exp4 <= expectedOut(age, 4, store4[(age / R) % 4]);
                exp3 <= expectedOut(age, 3, store3[(age / R) % 3]);
            end
            if (wr_en) begin
                store4[wr_addr] <= wr_data;
                if (int'(wr_addr) < 3) store3[wr_addr] <= wr_data;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (!rst) begin
            checkOutput("model4", {tick4, 4'b0000, en4, seg4}, exp4);
            checkOutput("model3", {tick3, 5'b00000, en3, seg3}, exp3);
        end
    end

    always @(posedge clk) begin
        #2;
        if (rst || !enable) begin
            lastTick = -1;
        end else if (tick4) begin
            if (lastTick >= 0) checkOutput("tickSpacing", 16'(edgeCount - lastTick), 16'd32);
            lastTick = edgeCount;
        end
    end

    task automatic gotoEdge(input int n);
        while (edgeCount < n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic applyStimulus(input logic [1:0] addr, input logic [3:0] data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic check4(input string name, input logic [3:0] en, input logic [6:0] seg);
        checkOutput(name, {tick4, 4'b0000, en4, seg4}, {1'b0, 4'b0000, en, seg});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        #1 rst = 1'b1;
        #1;
        checkOutput("resetState4", {tick4, 4'b0000, en4, seg4}, 16'd0);
        checkOutput("resetState3", {tick3, 5'b00000, en3, seg3}, 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        applyStimulus(2'd0, 4'd1);
        applyStimulus(2'd1, 4'd2);
        applyStimulus(2'd2, 4'd3);
        applyStimulus(2'd3, 4'd4);

        @(negedge clk);
        enable = 1'b1;
        base   = edgeCount + 1;
        gotoEdge(base + 2);
        check4("guardDark", 4'b0000, 7'h00);
        gotoEdge(base + 3);
        check4("digit0", 4'b0001, 7'h06);
        gotoEdge(base + 11);
        check4("digit1", 4'b0010, 7'h5B);
        gotoEdge(base + 19);
        check4("digit2", 4'b0100, 7'h4F);
        gotoEdge(base + 24);
        checkOutput("dut3Tick", 16'(tick3), 16'd1);
        gotoEdge(base + 27);
        check4("digit3", 4'b1000, 7'h66);
        checkOutput("dut3InvalidWrite", {tick3, 5'b00000, en3, seg3}, {9'd0, 7'h06} | 16'h0080);

        applyStimulus(2'd2, 4'hA);
        gotoEdge(base + 32);
        checkOutput("firstTick", 16'(tick4), 16'd1);
        gotoEdge(base + 51);
        check4("blankCode", 4'b0100, 7'h00);

        gotoEdge(base + 68);
        check4("beforeUpdate", 4'b0001, 7'h06);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 2'd0;
        wr_data = 4'd9;
        @(posedge clk);
        #2;
        check4("writeEdge", 4'b0001, 7'h06);
        @(negedge clk);
        wr_en = 1'b0;
        @(posedge clk);
        #2;
        check4("liveUpdate", 4'b0001, 7'h6F);

        gotoEdge(base + 84);
        check4("slot2Show", 4'b0100, 7'h00);
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        #2;
        checkOutput("disableDark", {tick4, 4'b0000, en4, seg4}, 16'd0);

        repeat (5) @(negedge clk);
        enable = 1'b1;
        base   = edgeCount + 1;
        gotoEdge(base + 2);
        check4("restartGuard", 4'b0000, 7'h00);
        gotoEdge(base + 3);
        check4("restartDigit0", 4'b0001, 7'h6F);

        gotoEdge(base + 40);
        @(posedge clk);
        #4;
        rst    = 1'b1;
        enable = 1'b0;
        #1;
        checkOutput("asyncReset4", {tick4, 4'b0000, en4, seg4}, 16'd0);
        checkOutput("asyncReset3", {tick3, 5'b00000, en3, seg3}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        enable = 1'b1;
        base   = edgeCount + 1;
        gotoEdge(base + 3);
        check4("storeCleared", 4'b0001, 7'h00);
        gotoEdge(base + 35);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
